// File: rtl/fcw_note_sequencer_if.sv
// Port-sharing bundle between the note sequencer, the host config requester and the
// single-port 4 x 24-bit FCW register file. The sequencer takes the slave view.
interface fcw_note_sequencer_if;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [1:0]  cfg_addr;
    logic [23:0] cfg_fcw;
    logic        ram_wr_en;
    logic [1:0]  ram_addr;
    logic [23:0] ram_d_in;
    logic [23:0] ram_d_out;

    // Environment side: host requester plus the FCW file.
    modport master (
        output cfg_valid, cfg_addr, cfg_fcw, ram_d_out,
        input  cfg_ready, ram_wr_en, ram_addr, ram_d_in
    );

    // Sequencer side.
    modport slave (
        input  cfg_valid, cfg_addr, cfg_fcw, ram_d_out,
        output cfg_ready, ram_wr_en, ram_addr, ram_d_in
    );
endinterface

// File: rtl/fcw_note_sequencer.sv
// FCW note sequencer: sole master of the FCW file port. Plays slots 0..NOTES-1 in a loop,
// holding each fetched FCW for note_cycles+1 cycles, and lets host writes through whenever
// the port is not needed for a playback fetch.
// Optional macro FCW_LIVE_UPDATE_EN: a write to the slot currently playing also updates
// fcw immediately instead of waiting for that slot's next fetch.
module fcw_note_sequencer #(
    parameter int unsigned NOTES = 4,
    parameter int unsigned DUR_W = 24
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 play,
    input  logic [DUR_W-1:0]     note_cycles,
    fcw_note_sequencer_if.slave  bus,
    output logic [23:0]          fcw,
    output logic                 fcw_valid,
    output logic [1:0]           note_idx,
    output logic                 seq_wrap
);

`ifdef FCW_LIVE_UPDATE_EN
    localparam bit LiveUpdate = 1'b1;
`else
    localparam bit LiveUpdate = 1'b0;
`endif

    localparam logic [1:0] LastIdx = 2'(NOTES - 1);

    typedef enum logic [1:0] {StIdle, StFetch, StPlay} state_e;

    state_e             state_q, state_d;
    logic [1:0]         note_idx_q, note_idx_d;
    logic [23:0]        fcw_q, fcw_d;
    logic               fcw_valid_q, fcw_valid_d;
    logic               seq_wrap_q, seq_wrap_d;
    logic [DUR_W-1:0]   cnt_q, cnt_d;
    logic               cfg_ready;
    logic               accept;

    // Port arbitration: playback fetch owns the port; otherwise host writes pass through.
    always_comb begin
        cfg_ready     = (state_q != StFetch);
        // Gated by rst so no write can leak out while reset is held.
        accept        = bus.cfg_valid && cfg_ready && rst;
        bus.cfg_ready = cfg_ready;
        bus.ram_wr_en = accept;
        bus.ram_addr  = accept ? bus.cfg_addr : note_idx_q;
        bus.ram_d_in  = bus.cfg_fcw;
    end

    // Playback next-state: fetch, hold for the programmed duration, advance or stop.
    always_comb begin
        state_d     = state_q;
        note_idx_d  = note_idx_q;
        fcw_d       = fcw_q;
        fcw_valid_d = fcw_valid_q;
        cnt_d       = cnt_q;
        unique case (state_q)
            StIdle: begin
                fcw_d       = '0;
                fcw_valid_d = 1'b0;
                note_idx_d  = '0;
                if (play) begin
                    state_d = StFetch;
                end
            end
            StFetch: begin
                if (play) begin
                    fcw_d       = bus.ram_d_out;
                    fcw_valid_d = 1'b1;
                    // A zero duration still plays one PLAY cycle.
                    cnt_d       = (note_cycles == '0) ? '0 : note_cycles - DUR_W'(1);
                    state_d     = StPlay;
                end
            end
            StPlay: begin
                if (play) begin
                    if (LiveUpdate && accept && (bus.cfg_addr == note_idx_q)) begin
                        fcw_d = bus.cfg_fcw;
                    end
                    if (cnt_q == '0) begin
                        note_idx_d = (note_idx_q == LastIdx) ? 2'd0 : note_idx_q + 2'd1;
                        state_d    = StFetch;
                    end else begin
                        cnt_d = cnt_q - DUR_W'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
        // Stopping always returns to a clean slot-0 restart point.
        if (state_q != StIdle && !play) begin
            state_d     = StIdle;
            note_idx_d  = '0;
            fcw_d       = '0;
            fcw_valid_d = 1'b0;
            cnt_d       = '0;
        end
        // Registered look-ahead so the pulse lands in the last cycle of the final slot.
        seq_wrap_d = (state_d == StPlay) && (cnt_d == '0) && (note_idx_d == LastIdx);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            note_idx_q  <= '0;
            fcw_q       <= '0;
            fcw_valid_q <= 1'b0;
            seq_wrap_q  <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            note_idx_q  <= note_idx_d;
            fcw_q       <= fcw_d;
            fcw_valid_q <= fcw_valid_d;
            seq_wrap_q  <= seq_wrap_d;
            cnt_q       <= cnt_d;
        end
    end

    assign fcw       = fcw_q;
    assign fcw_valid = fcw_valid_q;
    assign note_idx  = note_idx_q;
    assign seq_wrap  = seq_wrap_q;

endmodule

// File: doc/fcw_note_sequencer.md
Name: fcw_note_sequencer

Overview:
- Controller for the 4-entry, 24-bit FCW register file. It is the only master of that file's single port.
- Shares the port between a host config-write requester and a playback engine.
- The playback engine steps through slots 0..NOTES-1 and presents the fetched FCW to the NCO for a programmable number of cycles per note.

Parameters:
- NOTES, 4, number of slots sequenced (1..4). Slot index wraps from NOTES-1 back to 0.
- DUR_W, 24, width of the note-duration input and the internal down-counter.

Ports:
- clk  in  1  system clock. All state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset. 0 resets the block immediately; release is sampled on clk.
- play  in  1  level. 1 = run the sequence, 0 = stop.
- note_cycles  in  DUR_W  PLAY-state length per note. Sampled in FETCH. 0 is treated as 1.
- cfg_valid  in  1  host write request.
- cfg_ready  out  1  write accepted this cycle when cfg_valid && cfg_ready.
- cfg_addr  in  2  target slot.
- cfg_fcw  in  24  value to write.
- ram_wr_en  out  1  to FCW file wr_en.
- ram_addr  out  2  to FCW file addr.
- ram_d_in  out  24  to FCW file d_in.
- ram_d_out  in  24  from FCW file d_out. Combinational read of slot ram_addr.
- fcw  out  24  current note FCW to the NCO.
- fcw_valid  out  1  1 while fcw holds a fetched note.
- note_idx  out  2  slot currently playing.
- seq_wrap  out  1  1-cycle pulse when the last slot finishes.

Behaviour:
- Reset values:
  - State IDLE; note_idx=0; fcw=0; fcw_valid=0; seq_wrap=0; counter=0.
  - ram_wr_en=0; cfg_ready=1.
- States:
  - IDLE: fcw=0, fcw_valid=0. play=1 -> FETCH.
  - FETCH (1 cycle):
    - ram_addr=note_idx; fcw <= ram_d_out; fcw_valid <= 1.
    - cnt <= max(note_cycles,1)-1.
    - -> PLAY, or -> IDLE if play=0.
  - PLAY:
    - cnt decrements each cycle.
    - When cnt==0: note_idx <= (note_idx==NOTES-1) ? 0 : note_idx+1; seq_wrap=1 in that cycle if note_idx==NOTES-1; -> FETCH.
    - play=0 -> IDLE.
- Note period: fcw changes only at the end of each FETCH cycle. Each slot therefore spans note_cycles+1 cycles (the FETCH cycle plus the PLAY cycles).
- Stop: play=0 in FETCH or PLAY -> IDLE at the next edge. note_idx <= 0, fcw <= 0, fcw_valid <= 0. A restart always begins at slot 0.
- Port arbitration:
  - cfg_ready = (state != FETCH). Playback reads have priority.
  - On accept: ram_wr_en=1, ram_addr=cfg_addr, ram_d_in=cfg_fcw for exactly that cycle. The FCW file commits the value on the next edge.
  - All other cycles: ram_wr_en=0 and ram_addr=note_idx.
  - cfg_valid held during FETCH stalls exactly 1 cycle. Requester must hold addr/data stable until accepted.
- Simultaneous events:
  - cfg write accepted in IDLE in the same cycle play rises: the write commits at that edge, and the following FETCH reads the new value.
  - Write to the slot currently playing (no option): fcw is unchanged until that slot is next fetched.
- fcw, note_idx and seq_wrap are registered outputs. cfg_ready, ram_wr_en and ram_addr are combinational from state and cfg_valid.
- Reset asserted mid-operation returns all outputs to reset values immediately. No pending write survives.

Optional Feature:
- Macro FCW_LIVE_UPDATE_EN.
- Defined: an accepted write in PLAY with cfg_addr==note_idx also loads fcw <= cfg_fcw at the same edge. The new pitch is heard immediately, and cnt is not disturbed.
- Undefined: behaviour as above. fcw changes only in FETCH.

Test Plan:
- Reset: hold rst=0 mid-PLAY -> fcw=0, fcw_valid=0, note_idx=0, ram_wr_en=0 immediately.
- Basic sequence:
  - Stimulus: slots {0x100,0x200,0x300,0x400}, note_cycles=3, play=1.
  - Required: fcw steps 0x100->0x200->0x300->0x400->0x100, each held for 4 cycles. seq_wrap pulses once per loop, in the last cycle of slot 3.
- Stall: cfg_valid=1 (addr 2, 0xABC) arriving in a FETCH cycle -> cfg_ready=0 for 1 cycle, then accepted. Slot 2 later plays 0xABC.
- Same-slot write while slot 1 plays, value 0x555:
  - Macro off: fcw unchanged until the next fetch of slot 1.
  - Macro on: fcw=0x555 the next cycle.
- Edge values:
  - note_cycles=0 -> 2-cycle period per slot.
  - NOTES=2 -> wraps 0,1,0.
  - play dropped in slot 2, then reasserted -> restarts at slot 0.
- Simultaneous write and play in IDLE: write slot 0=0x777 in the same cycle play rises -> first fetched fcw=0x777.
